// File: rtl/duft_vec_sequencer.sv
// Command sequencer for the DUT pack/unpack stage: LOAD input words, RUN gated DUT clock, SNAP+DRAIN outputs.
// Owns every addr/en/mode strobe of the vector buffers.
module duft_vec_sequencer #(
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cycles,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [31:0]      dut_input_vec_addr,
    output logic [31:0]      dut_input_vec_from_axi,
    output logic             input_vec_en,
    output logic             input_vec_mode,
    output logic [31:0]      dut_output_vec_addr,
    input  logic [31:0]      dut_output_vec_to_axi,
    output logic             output_vec_en,
    output logic             output_vec_mode,
    output logic             dut_clk_en,
    output logic             busy,
    output logic             done
);
    localparam int MAX_W = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int WC_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [WC_W-1:0] IN_LAST  = WC_W'(IN_WORDS - 1);
    localparam logic [WC_W-1:0] OUT_LAST = WC_W'(OUT_WORDS - 1);

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_RUN    = 2'd1;
    localparam logic [1:0] OP_UNLOAD = 2'd2;
    localparam logic [1:0] OP_FULL   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SNAP, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            cyc_q   <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cyc_q   <= cyc_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        op_d                   = op_q;
        cyc_d                  = cyc_q;
        wcnt_d                 = wcnt_q;
        done_d                 = 1'b0;
        cmd_ready              = 1'b0;
        in_ready               = 1'b0;
        out_valid              = 1'b0;
        out_data               = '0;
        dut_input_vec_addr     = '0;
        dut_input_vec_from_axi = '0;
        input_vec_en           = 1'b0;
        input_vec_mode         = 1'b0;
        dut_output_vec_addr    = '0;
        output_vec_en          = 1'b0;
        output_vec_mode        = 1'b0;
        dut_clk_en             = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done cycle blocks acceptance so completion and a new command never overlap.
                cmd_ready = !done_q;
                if (cmd_valid && !done_q) begin
                    op_d   = cmd_op;
                    cyc_d  = cmd_cycles;
                    wcnt_d = '0;
                    case (cmd_op)
                        OP_RUN:    state_d = S_RUN;
                        OP_UNLOAD: state_d = S_SNAP;
                        default:   state_d = S_LOAD;
                    endcase
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    input_vec_en           = 1'b1;
                    input_vec_mode         = 1'b1;
                    dut_input_vec_addr     = 32'(wcnt_q);
                    dut_input_vec_from_axi = in_data;
                    if (wcnt_q == IN_LAST) begin
                        wcnt_d = '0;
                        if (op_q == OP_FULL) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A zero count still spends one cycle here, with the clock gated off.
                if (cyc_q != '0) begin
                    dut_clk_en = 1'b1;
                    cyc_d      = cyc_q - 1'b1;
                end
                if (cyc_q <= CNT_W'(1)) begin
                    if (op_q == OP_FULL) begin
                        state_d = S_SNAP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SNAP: begin
                output_vec_en   = 1'b1;
                output_vec_mode = 1'b1;
                wcnt_d          = '0;
                state_d         = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid           = 1'b1;
                dut_output_vec_addr = 32'(wcnt_q);
                out_data            = dut_output_vec_to_axi;
                if (out_ready) begin
                    if (wcnt_q == OUT_LAST) begin
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule
